// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control sequencer for the unprivileged RISC core.
// Owns the PC, the instruction register and the main FSM. Fetches over a req/ack
// handshake and drives the enable strobes of the decode/ALU/regfile/memory datapath.
//
// Optional feature: define CORE_SEQ_MISALIGN_TRAP_EN to trap (cause 3) when
// WRITE_BACK would load a PC whose low two bits are non-zero.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = pc)
//   ir, pc                latched instruction and its address
//   pc_next               next PC from branch/jump logic
//   state                 current FSM state code
//   decoder_illegal, is_load_store, mem_busy, is_div, div_busy  datapath status
//   exec_en, wb_en, retire, trap_taken  state-decoded strobes
//   instret               retired-instruction count
//   trap_cause, trap_pc   cause and PC of the most recent trap
module core_sequencer #(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter logic [XLEN-1:0] TRAP_VEC      = XLEN'(32'h100),
    parameter int unsigned     FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    output logic [2:0]      state,
    input  logic            decoder_illegal,
    input  logic            is_load_store,
    input  logic            mem_busy,
    input  logic            is_div,
    input  logic            div_busy,
    output logic            exec_en,
    output logic            wb_en,
    output logic            retire,
    output logic [31:0]     instret,
    output logic            trap_taken,
    output logic [1:0]      trap_cause,
    output logic [XLEN-1:0] trap_pc
);

    localparam int unsigned     TO_W_RAW = $clog2(FETCH_TIMEOUT + 1);
    localparam int unsigned     TO_W     = (TO_W_RAW < 1) ? 1 : TO_W_RAW;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH    = 3'b000,
        S_DECODE   = 3'b001,
        S_EXECUTE  = 3'b010,
        S_WB       = 3'b011,
        S_MEM_WAIT = 3'b100,
        S_TRAP     = 3'b101,
        S_DIV_WAIT = 3'b110
    } state_t;

    state_t          state_q;
    state_t          cur_st;
    logic [TO_W-1:0] to_cnt;
    logic            misalign;

    // Unused code 111 behaves as FETCH
    always_comb begin
        cur_st = state_q;
        if (3'(state_q) == 3'b111) cur_st = S_FETCH;
    end

`ifdef CORE_SEQ_MISALIGN_TRAP_EN
    assign misalign = (pc_next[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State-decoded strobes, all held low while in reset
    assign imem_req   = !reset && (cur_st == S_FETCH);
    assign exec_en    = !reset && (cur_st == S_EXECUTE);
    assign wb_en      = !reset && (cur_st == S_WB) && !misalign;
    assign retire     = !reset && (cur_st == S_WB) && !misalign;
    assign trap_taken = !reset && (cur_st == S_TRAP);
    assign imem_addr  = pc;
    assign state      = state_q;

    // Main sequencer: state, PC, IR, counters and trap record
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            instret    <= '0;
            trap_cause <= '0;
            trap_pc    <= '0;
            to_cnt     <= '0;
        end else begin
            case (cur_st)
                S_FETCH: begin
                    // ack beats a coincident timeout
                    if (imem_ack) begin
                        ir      <= imem_rdata;
                        to_cnt  <= '0;
                        state_q <= S_DECODE;
                    end else if ((FETCH_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                        to_cnt     <= '0;
                        trap_pc    <= pc;
                        trap_cause <= 2'd2;
                        state_q    <= S_TRAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (decoder_illegal) begin
                        trap_pc    <= pc;
                        trap_cause <= 2'd1;
                        state_q    <= S_TRAP;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_load_store)  state_q <= S_MEM_WAIT;
                    else if (is_div)    state_q <= S_DIV_WAIT;
                    else                state_q <= S_WB;
                end
                S_MEM_WAIT: begin
                    if (!mem_busy) state_q <= S_WB;
                end
                S_DIV_WAIT: begin
                    if (!div_busy) state_q <= S_WB;
                end
                S_WB: begin
                    if (misalign) begin
                        trap_pc    <= pc;
                        trap_cause <= 2'd3;
                        state_q    <= S_TRAP;
                    end else begin
                        pc      <= pc_next;
                        instret <= instret + 32'd1;
                        state_q <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    pc      <= TRAP_VEC;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction outcomes are predicted
// from the sequencing rules and queued; a monitor checks them as the DUT retires or traps.
module tb_core_sequencer;

    localparam int          FETCH_TO = 15;
    localparam logic [31:0] TVEC     = 32'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, ir, pc, pc_next, instret, trap_pc;
    logic [2:0]  state;
    logic        decoder_illegal, is_load_store, mem_busy, is_div, div_busy;
    logic        exec_en, wb_en, retire, trap_taken;
    logic [1:0]  trap_cause;

    core_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .pc_next(pc_next), .state(state),
        .decoder_illegal(decoder_illegal), .is_load_store(is_load_store), .mem_busy(mem_busy),
        .is_div(is_div), .div_busy(div_busy),
        .exec_en(exec_en), .wb_en(wb_en), .retire(retire), .instret(instret),
        .trap_taken(trap_taken), .trap_cause(trap_cause), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_trap;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] ir;
        int          lat;
        int          req;
        int          exec;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] m_pc, m_instret, m_ir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks each retire/trap against the queued prediction
    int last_evt = 0;
    int exec_cnt = 0;
    int req_cnt  = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            last_evt = cyc;
            exec_cnt = 0;
            req_cnt  = 0;
        end else begin
            if (exec_en) exec_cnt++;
            if (imem_req) begin
                req_cnt++;
                if (exp_q.size() != 0) chk("imem_addr", imem_addr, exp_q[0].pc);
            end
            if (retire || trap_taken) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(retire), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("trap_taken", 32'(trap_taken), 32'(e.is_trap));
                    chk("retire", 32'(retire), 32'(!e.is_trap));
                    chk("wb_en", 32'(wb_en), 32'(!e.is_trap));
                    chk("pc_at_event", pc, e.pc);
                    chk("instret_at_event", instret, e.instret);
                    chk("ir", ir, e.ir);
                    chk("latency", 32'(cyc - last_evt), 32'(e.lat));
                    chk("req_cycles", 32'(req_cnt), 32'(e.req));
                    chk("exec_pulses", 32'(exec_cnt), 32'(e.exec));
                    if (e.is_trap) begin
                        chk("trap_cause", 32'(trap_cause), 32'(e.cause));
                        chk("trap_pc", trap_pc, e.pc);
                    end
                end
                last_evt = cyc;
                exec_cnt = 0;
                req_cnt  = 0;
            end
        end
    end

    // Predict one instruction's outcome, queue it, then drive it cycle by cycle.
    // Called at the start of its first FETCH cycle.
    task automatic run_instr(input int d, input bit ill, input bit ls, input bit dv,
                             input int n, input logic [31:0] nxt);
        exp_t        e;
        logic [31:0] rd;
        bit          to, mis;
        int          wt;
        rd  = $urandom;
        to  = (d >= FETCH_TO);
        wt  = (ls || dv) ? n + 1 : 0;
        mis = 1'b0;
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
        mis = (nxt[1:0] != 2'b00);
`endif
        e.pc = m_pc; e.instret = m_instret; e.cause = 2'd0;
        if (to) begin
            e.is_trap = 1; e.cause = 2'd2; e.lat = FETCH_TO + 1; e.req = FETCH_TO;
            e.exec = 0; e.ir = m_ir;
        end else begin
            m_ir = rd; e.ir = rd; e.req = d + 1;
            if (ill) begin
                e.is_trap = 1; e.cause = 2'd1; e.lat = d + 3; e.exec = 0;
            end else if (mis) begin
                e.is_trap = 1; e.cause = 2'd3; e.lat = 5 + d + wt; e.exec = 1;
            end else begin
                e.is_trap = 0; e.lat = 4 + d + wt; e.exec = 1;
            end
        end
        exp_q.push_back(e);
        if (e.is_trap) m_pc = TVEC;
        else begin m_pc = nxt; m_instret = m_instret + 1; end

        decoder_illegal = ill; is_load_store = ls; is_div = dv; pc_next = nxt;
        imem_rdata = rd; mem_busy = 0; div_busy = 0; imem_ack = 0;
        if (to) begin
            repeat (FETCH_TO + 1) step();
            return;
        end
        repeat (d) step();
        imem_ack = 1;
        step();                         // DECODE
        imem_ack = 0;
        step();                         // EXECUTE or TRAP
        if (ill) begin step(); return; end
        if (ls || dv) begin
            step();                     // first wait cycle
            for (int i = 0; i < n; i++) begin
                if (ls) begin mem_busy = 1; div_busy = 1'($urandom_range(0, 1)); end
                else begin div_busy = 1; mem_busy = 1'($urandom_range(0, 1)); end
                imem_ack = 1'($urandom_range(0, 1));
                step();
            end
            if (ls) mem_busy = 0; else div_busy = 0;
            imem_ack = 0;
            step();                     // WRITE_BACK
        end else begin
            step();                     // WRITE_BACK
        end
        mem_busy = 0; div_busy = 0;
        step();                         // FETCH, or TRAP on misalign
        if (mis) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] r, nxt;
        int          d;
        reset = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; pc_next = 32'h4;
        decoder_illegal = 0; is_load_store = 0; mem_busy = 0; is_div = 0; div_busy = 0;
        m_pc = 0; m_instret = 0; m_ir = 0;

        step();
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_trap_cause", 32'(trap_cause), 32'(0));
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_strobes", 32'({imem_req, exec_en, wb_en, retire, trap_taken}), 32'(0));
        step();
        chk("rst_ack_ignored", 32'(state), 32'(0));
        reset = 0; imem_ack = 0;

        // Three back-to-back ALU instructions, ack on first cycle
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, m_pc + 32'd4);
        drain();
        chk("instret_after3", instret, 32'd3);
        chk("pc_after3", pc, 32'd12);

        // Fetch delays: late ack, ack coinciding with timeout, no ack at all
        run_instr(5, 0, 0, 0, 0, m_pc + 32'd4);
        run_instr(FETCH_TO - 1, 0, 0, 0, 0, m_pc + 32'd4);
        run_instr(FETCH_TO + 5, 0, 0, 0, 0, m_pc + 32'd4);
        drain();
        chk("pc_after_timeout", pc, TVEC);

        // Waits: load, divide, load+divide together, then illegal
        run_instr(0, 0, 1, 0, 3, m_pc + 32'd4);
        run_instr(0, 0, 0, 1, 4, m_pc + 32'd4);
        run_instr(1, 0, 1, 1, 2, m_pc + 32'd4);
        run_instr(0, 1, 0, 0, 0, m_pc + 32'd4);
        run_instr(2, 0, 0, 0, 0, 32'h6);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            if (r[3:0] == 4'd0) d = FETCH_TO - 1 + int'(r[5:4]);
            else d = $urandom_range(0, 3);
            r = $urandom;
            if (r[2:0] == 3'd0) nxt = {r[31:2], 2'b10};
            else if (r[3]) nxt = m_pc + 32'd4;
            else nxt = {16'h0, r[15:2], 2'b00};
            run_instr(d, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 4), nxt);
        end
        drain();

        // Reset while waiting on the divider
        decoder_illegal = 0; is_load_store = 0; is_div = 1; pc_next = 32'h40;
        imem_ack = 1;
        step();                         // DECODE
        imem_ack = 0;
        step();                         // EXECUTE
        div_busy = 1;
        step();                         // DIV_WAIT
        step();                         // DIV_WAIT
        chk("div_wait_state", 32'(state), 32'(6));
        reset = 1; div_busy = 0;
        step();
        chk("midrst_state", 32'(state), 32'(0));
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instret", instret, 32'h0);
        chk("midrst_strobes", 32'({imem_req, exec_en, wb_en, retire, trap_taken}), 32'(0));
        reset = 0;
        m_pc = 0; m_instret = 0; m_ir = 0;
        run_instr(0, 0, 0, 0, 0, 32'h4);
        run_instr(1, 0, 0, 0, 0, 32'h8);
        drain();
        chk("final_instret", instret, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
